// File: rtl/sync_fifo_if.sv
// sync_fifo_if: write/read handshake bundle plus status for sync_fifo.
// The FIFO connects through the slave modport; the producer/consumer side
// uses the master modport.
interface sync_fifo_if #(
  parameter int  DATA_WIDTH = 1,
  parameter type TYPE       = logic [DATA_WIDTH-1:0],
  parameter int  DEPTH      = 2
);
  localparam int AW = $clog2(DEPTH);

  logic        w_valid;
  logic        w_ready;
  TYPE         w_data;
  logic        r_valid;
  logic        r_ready;
  TYPE         r_data;
  logic [AW:0] level;
  logic        almost_full;

  modport master (
    output w_valid, w_data, r_ready,
    input  w_ready, r_valid, r_data, level, almost_full
  );

  modport slave (
    input  w_valid, w_data, r_ready,
    output w_ready, r_valid, r_data, level, almost_full
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with valid/ready on both sides, registered
// occupancy and almost-full status. Pointers are AW+1 bit binary counters;
// the extra top bit tells full from empty when the low bits match.
// Optional feature macro: SYNC_FIFO_FULL_PASS_EN lets a push be accepted
// while full in the same cycle as a pop (adds an r_ready -> w_ready path).
module sync_fifo #(
  parameter int  DATA_WIDTH  = 1,
  parameter type TYPE        = logic [DATA_WIDTH-1:0],
  parameter int  DEPTH       = 2,
  parameter int  ALMOST_FULL = DEPTH - 1
) (
  input  logic       clk,
  input  logic       rstn,
  sync_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_LEVEL  = (AW+1)'(ALMOST_FULL);
  localparam logic [AW:0] FULL_DIFF = {1'b1, {AW{1'b0}}};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sync_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_almost_full
    $fatal(1, "sync_fifo: ALMOST_FULL must be in 1..DEPTH");
  end

  TYPE         mem [DEPTH];
  logic [AW:0] writeptr;
  logic [AW:0] readptr;
  logic [AW:0] level_q;
  logic        empty;
  logic        full;
  logic        almost_full_q;

  logic        w_ready_c;
  logic        push;
  logic        pop;
  logic [AW:0] writeptr_next;
  logic [AW:0] readptr_next;
  logic [AW:0] level_next;

`ifdef SYNC_FIFO_FULL_PASS_EN
  assign w_ready_c = !full || bus.r_ready;
`else
  assign w_ready_c = !full;
`endif

  assign push          = bus.w_valid && w_ready_c;
  assign pop           = !empty && bus.r_ready;
  assign writeptr_next = writeptr + {{AW{1'b0}}, push};
  assign readptr_next  = readptr + {{AW{1'b0}}, pop};
  assign level_next    = writeptr_next - readptr_next;

  // Pointer and status registers; reset empties the FIFO and drops its contents.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      writeptr      <= '0;
      readptr       <= '0;
      empty         <= 1'b1;
      full          <= 1'b0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      writeptr      <= writeptr_next;
      readptr       <= readptr_next;
      empty         <= (writeptr_next == readptr_next);
      full          <= ((writeptr_next ^ readptr_next) == FULL_DIFF);
      level_q       <= level_next;
      almost_full_q <= (level_next >= AF_LEVEL);
    end
  end

  // Storage write; contents are not reset and a push during reset is lost.
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      mem[writeptr[AW-1:0]] <= bus.w_data;
    end
  end

  assign bus.w_ready     = w_ready_c;
  assign bus.r_valid     = !empty;
  assign bus.r_data      = mem[readptr[AW-1:0]];
  assign bus.level       = level_q;
  assign bus.almost_full = almost_full_q;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed test-plan sequences followed by randomized traffic,
// all checked every cycle against a queue-based model of the FIFO, plus
// literal expectations at the key points of the directed sequences.
module tb_sync_fifo;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
`ifdef SYNC_FIFO_FULL_PASS_EN
  localparam bit PASS = 1'b1;
`else
  localparam bit PASS = 1'b0;
`endif

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  bit   model_ok;
  logic [7:0] model_q [$];

  sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(DEPTH)) bus ();

  sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH),
    .ALMOST_FULL(AF)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
               name, $time, actual, actual, expected, expected);
    end
  endtask

  // Drive one cycle of inputs, let the next rising edge sample them, and
  // return shortly after that edge with the inputs still held.
  task automatic apply_stimulus(input bit rst_n, input bit wv, input logic [7:0] wd, input bit rr);
    rstn        = rst_n;
    bus.w_valid = wv;
    bus.w_data  = wd;
    bus.r_ready = rr;
    @(posedge clk);
    #2;
  endtask

  // Reference model: a queue of stored bytes updated from the handshake rules.
  always @(posedge clk) begin
    int  sz;
    bit  do_pop;
    bit  do_push;
    if (!rstn) begin
      model_q.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      sz      = model_q.size();
      do_pop  = (sz > 0) && bus.r_ready;
      do_push = bus.w_valid && ((sz < DEPTH) || (PASS && bus.r_ready));
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(bus.w_data);
    end
  end

  // Compare all outputs against the model away from the active edge.
  always @(negedge clk) begin
    int sz;
    if (model_ok) begin
      sz = model_q.size();
      check_output("r_valid", int'(bus.r_valid), int'(sz > 0));
      check_output("w_ready", int'(bus.w_ready), int'((sz < DEPTH) || (PASS && bus.r_ready)));
      check_output("level", int'(bus.level), sz);
      check_output("almost_full", int'(bus.almost_full), int'(sz >= AF));
      if (sz > 0) check_output("r_data", int'(bus.r_data), int'(model_q[0]));
    end
  end

  initial begin
    int wprob;
    int rprob;
    checks      = 0;
    errors      = 0;
    model_ok    = 1'b0;
    rstn        = 1'b0;
    bus.w_valid = 1'b0;
    bus.w_data  = 8'h00;
    bus.r_ready = 1'b0;

    // Reset held two cycles with a write offered.
    apply_stimulus(1'b0, 1'b1, 8'hAA, 1'b0);
    apply_stimulus(1'b0, 1'b1, 8'hAA, 1'b0);
    check_output("rst_r_valid", int'(bus.r_valid), 0);
    check_output("rst_w_ready", int'(bus.w_ready), 1);
    check_output("rst_level", int'(bus.level), 0);
    check_output("rst_almost_full", int'(bus.almost_full), 0);

    // Fill with 0x11..0x44, then a held-off 0x55.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b1, 8'((i + 1) * 8'h11), 1'b0);
      check_output("fill_level", int'(bus.level), i + 1);
      check_output("fill_almost_full", int'(bus.almost_full), int'(i >= 2));
    end
    check_output("fill_w_ready", int'(bus.w_ready), 0);
    apply_stimulus(1'b1, 1'b1, 8'h55, 1'b0);
    check_output("fill_hold_level", int'(bus.level), 4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      check_output("drain_data", int'(bus.r_data), (i + 1) * 8'h11);
      apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1);
    end
    check_output("drain_r_valid", int'(bus.r_valid), 0);
    check_output("drain_level", int'(bus.level), 0);

    // Streaming with one priming push; pointers wrap several times.
    apply_stimulus(1'b1, 1'b1, 8'd0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      check_output("stream_data", int'(bus.r_data), i - 1);
      apply_stimulus(1'b1, 1'b1, 8'(i), 1'b1);
      check_output("stream_level", int'(bus.level), 1);
    end
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1);
    check_output("stream_end_level", int'(bus.level), 0);

    // Full with concurrent pop and push of 0x99.
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 8'(8'hA0 + i), 1'b0);
    apply_stimulus(1'b1, 1'b1, 8'h99, 1'b1);
    check_output("fullpop_level", int'(bus.level), PASS ? 4 : 3);
    if (PASS) apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
    else      apply_stimulus(1'b1, 1'b1, 8'h99, 1'b0);
    check_output("fullpop_level_after", int'(bus.level), 4);
    for (int i = 0; i < 4; i++) begin
      check_output("fullpop_data", int'(bus.r_data), (i < 3) ? (8'hA1 + i) : 8'h99);
      apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1);
    end
    check_output("fullpop_empty", int'(bus.r_valid), 0);

    // Reset mid-operation with two entries stored.
    apply_stimulus(1'b1, 1'b1, 8'h5A, 1'b0);
    apply_stimulus(1'b1, 1'b1, 8'h5B, 1'b0);
    check_output("midrst_level_before", int'(bus.level), 2);
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check_output("midrst_level", int'(bus.level), 0);
    check_output("midrst_r_valid", int'(bus.r_valid), 0);
    check_output("midrst_w_ready", int'(bus.w_ready), 1);
    apply_stimulus(1'b1, 1'b1, 8'h77, 1'b0);
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
    check_output("midrst_new_data", int'(bus.r_data), 8'h77);
    check_output("midrst_new_level", int'(bus.level), 1);

    // Randomized traffic with varying write/read pressure and rare resets.
    wprob = 50;
    rprob = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        wprob = $urandom_range(10, 95);
        rprob = $urandom_range(10, 95);
      end
      apply_stimulus($urandom_range(0, 199) != 0,
                     $urandom_range(0, 99) < wprob,
                     8'($urandom_range(0, 255)),
                     $urandom_range(0, 99) < rprob);
    end

    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock FIFO with a valid/ready handshake on both the write and read sides. It carries streams between producers and consumers within one clock domain. It also provides occupancy and almost-full status for flow control. Push and pop pointers are binary, so no cross-domain conversion is needed.

## Interface
- `DATA_WIDTH`, default 1: payload width when `TYPE` is left at its default.
- `TYPE`, default `logic [DATA_WIDTH-1:0]`: payload type; storage width is `$bits(TYPE)`.
- `DEPTH`, default 2: number of entries. Must be a power of 2 and at least 2; otherwise elaboration fails with `$fatal`.
- `ALMOST_FULL`, default `DEPTH-1`: threshold for `almost_full`. Valid range is 1..DEPTH; otherwise `$fatal`.

Ports (`AW = $clog2(DEPTH)`):
- `clk` input 1: single clock; all logic on its rising edge.
- `rstn` input 1: reset, synchronous and active-low, sampled on the rising edge of `clk`.
- `w_valid` input 1: producer offers `w_data`.
- `w_ready` output 1: FIFO accepts; a push occurs when `w_valid && w_ready`.
- `w_data` input `TYPE`: push payload.
- `r_valid` output 1: `r_data` holds the oldest entry.
- `r_ready` input 1: consumer takes; a pop occurs when `r_valid && r_ready`.
- `r_data` output `TYPE`: head entry, meaningful only while `r_valid`.
- `level` output AW+1: registered entry count, 0..DEPTH.
- `almost_full` output 1: registered flag, `level >= ALMOST_FULL`.

## Operation
- **State registers:**
  - `writeptr` and `readptr`, each AW+1 bits, binary, incrementing modulo 2^(AW+1).
  - `empty`, `full` and `level`, all registered.
  - Storage is an array of DEPTH flops/LUTRAM; the write address is `writeptr[AW-1:0]`.
- **Handshake outputs:**
  - `r_valid = !empty`.
  - `r_data = mem[readptr[AW-1:0]]`, a combinational read of registered state.
  - `w_ready = !full`, except as extended under Configuration.
- **Next-state equations:**
  - `writeptr_next = writeptr + push`.
  - `readptr_next = readptr + pop`.
  - `empty_next = (writeptr_next == readptr_next)`.
  - `full_next = (writeptr_next ^ readptr_next) == {1'b1, AW'b0}`.
  - `level_next = writeptr_next - readptr_next`, in AW+1-bit arithmetic.
- **Boundary cases:**
  - Empty: `r_valid=0` and no pop occurs regardless of `r_ready`. A push makes `r_valid=1` on the next cycle.
  - Full: `w_valid` is ignored, memory and pointers are unchanged, and `w_data` is discarded.
  - Simultaneous push and pop (non-empty, non-full): both pointers advance, and `level`, `empty` and `full` are unchanged.
  - Wrap-around: pointer bit AW toggles every DEPTH operations, which distinguishes full from empty when the low bits are equal.
- **Handshake rules:**
  - Producers and consumers must not make `valid` depend on `ready`.
  - This block never makes `r_valid` depend on `r_ready`.
- **Reset:**
  - `rstn=0` at a rising edge forces `writeptr=0`, `readptr=0`, `empty=1`, `full=0`, `level=0`.
  - Memory contents are not reset.
  - Entries in flight at reset are dropped; a push in the reset cycle is lost.
- **Outputs during and after reset:**
  - After reset: `r_valid=0`, `w_ready=1`, `level=0`, `almost_full=0` (since ALMOST_FULL ≥ 1).
  - `r_data` is X until the first push.

## Timing
- Push-to-visible latency is 1 cycle: a push at edge N gives `r_valid=1` and `r_data` valid after edge N.
- Pop-to-free latency is 1 cycle without the macro: a pop at edge N while full gives `w_ready=1` after edge N.
- `level` and `almost_full` reflect all handshakes up to and including the last edge.
- Combinational paths:
  - Data path: `w_data`→storage only, no combinational path to `r_data`.
  - Control path: none without the macro.
- Throughput is one push and one pop per cycle sustained.

## Configuration
- **`SYNC_FIFO_FULL_PASS_EN` defined:**
  - `w_ready = !full || r_ready`. While full, a push is accepted in the same cycle as a pop.
  - `full` stays 1, `level` stays DEPTH, the head entry is popped and the new entry is written into the freed slot.
  - This adds a combinational `r_ready`→`w_ready` path.
- **`SYNC_FIFO_FULL_PASS_EN` not defined:**
  - `w_ready = !full`, with no combinational input-to-output path.
  - While full, a concurrent pop and push attempt accepts only the pop.

## Test plan
Default configuration: DEPTH=4, DATA_WIDTH=8, ALMOST_FULL=3.
- **Reset:** hold `rstn=0` for 2 cycles with `w_valid=1` → `r_valid=0`, `w_ready=1`, `level=0`, `almost_full=0`. Nothing is stored.
- **Fill:**
  - Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `r_ready=0` → `level` reads 1,2,3,4.
  - `almost_full` rises after the 3rd push; `w_ready=0` after the 4th.
  - A 5th write of 0x55 is held off and is not stored.
- **Drain:** with `r_ready=1`, read → 0x11, 0x22, 0x33, 0x44 in order. `r_valid=0` after the 4th pop, and `level` returns to 0.
- **Streaming and wrap-around:**
  - Push and pop every cycle for 20 cycles with an incrementing byte, starting after 1 priming push.
  - Required: `level` stays 1 and output equals input delayed by 1 cycle.
  - Pointers wrap past 7→0 with no loss.
- **Full with concurrent pop:** fill to 4, then assert `w_valid=1` (0x99) and `r_ready=1` together.
  - Macro on: 0x99 is accepted, `level` stays 4, and 0x99 emerges as the 4th subsequent read.
  - Macro off: only the pop occurs, `level`=3, and 0x99 is accepted the next cycle.
- **Reset mid-operation:** with `level`=2, assert `rstn=0` for 1 cycle → `level=0`, `r_valid=0`, `w_ready=1`. The old entries never appear at the output.
